// File: rtl/ar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ar_pkg
// Description : Shared types and default sizes for the burst address register.
// Revision    : 1.0  initial release
// ============================================================================
package ar_pkg;

    localparam int C_WIDTH_DEFAULT = 12;
    localparam int C_CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } ar_state_e;

    // Datapath action selected by the controller for the coming edge.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } ar_op_e;

endpackage
`default_nettype wire

// File: rtl/ar_burst_address_register_if.sv
`default_nettype none
// ============================================================================
// Module      : ar_burst_address_register_if
// Description : Command and status bundle of the burst address register.
// Revision    : 1.0  initial release
// ============================================================================
interface ar_burst_address_register_if #(
    parameter int WIDTH = ar_pkg::C_WIDTH_DEFAULT,
    parameter int CNT_W = ar_pkg::C_CNT_W_DEFAULT
);
    logic             CLR_clear;
    logic             LD_load;
    logic             INR_increment;
    logic             DCR_decrement;
    logic             BST_start;
    logic [CNT_W-1:0] BST_count;
    logic [WIDTH-1:0] AR_input;
    logic [WIDTH-1:0] AR_output;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output CLR_clear, LD_load, INR_increment, DCR_decrement,
        output BST_start, BST_count, AR_input,
        input  AR_output, busy, done, wrap
    );

    modport slave (
        input  CLR_clear, LD_load, INR_increment, DCR_decrement,
        input  BST_start, BST_count, AR_input,
        output AR_output, busy, done, wrap
    );
endinterface
`default_nettype wire

// File: rtl/ar_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ar_burst_ctrl
// Description : Burst FSM and remaining counter; decodes commands into one op.
// Revision    : 1.0  initial release
// ============================================================================
module ar_burst_ctrl
    import ar_pkg::*;
#(
    parameter int CNT_W = C_CNT_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             ld,
    input  wire logic             inr,
    input  wire logic             dcr,
    input  wire logic             bst_start,
    input  wire logic [CNT_W-1:0] bst_count,
    output ar_op_e                op,
    output logic                  busy,
    output logic                  done
);

    ar_state_e        state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op          = OP_HOLD;
        case (state_q)
            BURST: begin
                if (clr) begin
                    op          = OP_CLR;
                    remaining_d = '0;
                    state_d     = IDLE;
                end else begin
                    op          = OP_INC;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                // IDLE and DONE share command decoding; only IDLE may start a burst.
                state_d = IDLE;
                if (clr) begin
                    op = OP_CLR;
                end else if (bst_start && (state_q == IDLE)) begin
                    remaining_d = bst_count;
                    state_d     = (bst_count != '0) ? BURST : DONE;
                    op          = ld ? OP_LOAD : OP_HOLD;
                end else if (ld) begin
                    op = OP_LOAD;
                end else if (inr) begin
                    op = OP_INC;
                end else if (dcr) begin
                    op = OP_DEC;
                end
            end
        endcase
    end

    assign busy = (state_q == BURST);
    assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: rtl/ar_burst_address_register.sv
`default_nettype none
// ============================================================================
// Module      : ar_burst_address_register
// Description : Address register with load/inc/dec/clear and auto-increment bursts.
// Revision    : 1.0  initial release
// ============================================================================
module ar_burst_address_register
    import ar_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT,
    parameter int CNT_W = C_CNT_W_DEFAULT
) (
    input  wire logic                    clk_clock,
    input  wire logic                    rst_reset,
    ar_burst_address_register_if.slave   bus
);

    ar_op_e           op;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic             wrap_q, wrap_d;

    ar_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk_clock),
        .rst       (rst_reset),
        .clr       (bus.CLR_clear),
        .ld        (bus.LD_load),
        .inr       (bus.INR_increment),
        .dcr       (bus.DCR_decrement),
        .bst_start (bus.BST_start),
        .bst_count (bus.BST_count),
        .op        (op),
        .busy      (bus.busy),
        .done      (bus.done)
    );

    always_comb begin
        ar_d   = ar_q;
        wrap_d = 1'b0;
        case (op)
            OP_CLR:  ar_d = '0;
            OP_LOAD: ar_d = bus.AR_input;
            OP_INC: begin
                ar_d   = ar_q + WIDTH'(1);
                wrap_d = &ar_q;
            end
            OP_DEC: begin
                ar_d   = ar_q - WIDTH'(1);
                wrap_d = ~|ar_q;
            end
            default: ar_d = ar_q;
        endcase
    end

    always_ff @(posedge clk_clock) begin
        if (rst_reset) begin
            ar_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            ar_q   <= ar_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.AR_output = ar_q;
    assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_ar_burst_address_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_ar_burst_address_register
// Description : Directed and random stimulus against a cycle-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ar_burst_address_register;

    localparam int W    = 12;
    localparam int CW   = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk_clock = 1'b0;
    logic rst_reset;

    always #5 clk_clock = ~clk_clock;

    ar_burst_address_register_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    ar_burst_address_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_clock (clk_clock),
        .rst_reset (rst_reset),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: AR value, increments left in the burst, pending flags.
    int m_ar   = 0;
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_wrap = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_cmd(input bit clr, input bit ld, input bit inr, input bit dcr,
                           input bit bst, input int cnt, input int din);
        bus.CLR_clear     = clr;
        bus.LD_load       = ld;
        bus.INR_increment = inr;
        bus.DCR_decrement = dcr;
        bus.BST_start     = bst;
        bus.BST_count     = cnt[CW-1:0];
        bus.AR_input      = din[W-1:0];
    endtask

    // Advance one edge: predict from the rules, clock, then compare every output.
    task automatic cycle();
        int n_ar, n_left;
        bit n_done, n_wrap;
        n_ar   = m_ar;
        n_left = m_left;
        n_done = 1'b0;
        n_wrap = 1'b0;
        if (rst_reset) begin
            n_ar   = 0;
            n_left = 0;
        end else if (m_left > 0) begin
            if (bus.CLR_clear) begin
                n_ar   = 0;
                n_left = 0;
            end else begin
                n_wrap = (m_ar == MASK);
                n_ar   = (m_ar + 1) & MASK;
                n_left = m_left - 1;
                n_done = (n_left == 0);
            end
        end else begin
            if (bus.CLR_clear) begin
                n_ar = 0;
            end else if (bus.BST_start && !m_done) begin
                if (bus.LD_load) n_ar = int'(bus.AR_input);
                n_left = int'(bus.BST_count);
                n_done = (n_left == 0);
            end else if (bus.LD_load) begin
                n_ar = int'(bus.AR_input);
            end else if (bus.INR_increment) begin
                n_wrap = (m_ar == MASK);
                n_ar   = (m_ar + 1) & MASK;
            end else if (bus.DCR_decrement) begin
                n_wrap = (m_ar == 0);
                n_ar   = (m_ar - 1) & MASK;
            end
        end
        @(posedge clk_clock);
        #1;
        m_ar   = n_ar;
        m_left = n_left;
        m_done = n_done;
        m_wrap = n_wrap;
        check_val("ar",   32'(bus.AR_output), 32'(m_ar));
        check_val("busy", 32'(bus.busy),      32'(m_left > 0));
        check_val("done", 32'(bus.done),      32'(m_done));
        check_val("wrap", 32'(bus.wrap),      32'(m_wrap));
    endtask

    task automatic load_ar(input int v);
        set_cmd(0, 1, 0, 0, 0, 0, v);
        cycle();
        set_cmd(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r;
        rst_reset = 1'b1;
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst_reset = 1'b0;

        // Reset overrides a concurrent load
        load_ar(12'h5A5);
        rst_reset = 1'b1;
        set_cmd(0, 1, 0, 0, 0, 0, 12'h777);
        cycle();
        rst_reset = 1'b0;
        check_val("reset_ar",   32'(bus.AR_output), 32'h000);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        check_val("reset_wrap", 32'(bus.wrap), 32'd0);

        // Command priority
        load_ar(12'h123);
        set_cmd(1, 1, 1, 0, 0, 0, 12'h0F0);
        cycle();
        check_val("prio_clr", 32'(bus.AR_output), 32'h000);
        set_cmd(0, 1, 1, 0, 0, 0, 12'h0F0);
        cycle();
        check_val("prio_ld", 32'(bus.AR_output), 32'h0F0);
        set_cmd(0, 0, 1, 1, 0, 0, 0);
        cycle();
        check_val("prio_inr", 32'(bus.AR_output), 32'h0F1);

        // Wrap both directions
        load_ar(12'hFFF);
        set_cmd(0, 0, 1, 0, 0, 0, 0);
        cycle();
        check_val("wrap_inc_ar", 32'(bus.AR_output), 32'h000);
        check_val("wrap_inc",    32'(bus.wrap), 32'd1);
        set_cmd(0, 0, 0, 1, 0, 0, 0);
        cycle();
        check_val("wrap_dec_ar", 32'(bus.AR_output), 32'hFFF);
        check_val("wrap_dec",    32'(bus.wrap), 32'd1);
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("wrap_clear", 32'(bus.wrap), 32'd0);

        // Burst of 3 from a concurrent load, INR ignored while busy
        set_cmd(0, 1, 0, 0, 1, 3, 12'h100);
        cycle();
        check_val("bst_start_ar", 32'(bus.AR_output), 32'h100);
        set_cmd(0, 0, 1, 0, 0, 0, 0);
        cycle();
        cycle();
        cycle();
        check_val("bst_end_ar",   32'(bus.AR_output), 32'h103);
        check_val("bst_end_done", 32'(bus.done), 32'd1);
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("bst_after_done", 32'(bus.done), 32'd0);

        // Abort a burst of 8 with clear
        set_cmd(0, 1, 0, 0, 1, 8, 12'h010);
        cycle();
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check_val("abort_pre_ar", 32'(bus.AR_output), 32'h012);
        set_cmd(1, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("abort_ar",   32'(bus.AR_output), 32'h000);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("abort_done", 32'(bus.done), 32'd0);

        // Zero-length burst
        load_ar(12'h055);
        set_cmd(0, 0, 0, 0, 1, 0, 0);
        cycle();
        check_val("zero_done", 32'(bus.done), 32'd1);
        check_val("zero_busy", 32'(bus.busy), 32'd0);
        check_val("zero_ar",   32'(bus.AR_output), 32'h055);
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_reset = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 3);
            set_cmd($urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5)),
                    (r == 0) ? MASK : (r == 1) ? 0 : int'($urandom_range(0, MASK)));
            cycle();
        end
        rst_reset = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ar_burst_address_register.md
AR_BURST_ADDRESS_REGISTER -- requirements
Module: ar_burst_address_register

Interface
REQ-001 SHALL have parameter WIDTH, default 12, address register width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, burst-length field width in bits.
REQ-003 SHALL have port clk_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port CLR_clear  input  1  synchronous clear of AR; aborts any burst.
REQ-006 SHALL have port LD_load  input  1  load AR from AR_input.
REQ-007 SHALL have port INR_increment  input  1  AR = AR + 1.
REQ-008 SHALL have port DCR_decrement  input  1  AR = AR - 1.
REQ-009 SHALL have port BST_start  input  1  start an auto-increment burst.
REQ-010 SHALL have port BST_count  input  CNT_W  number of burst increments, sampled with BST_start.
REQ-011 SHALL have port AR_input  input  WIDTH  load value.
REQ-012 SHALL have port AR_output  output  WIDTH  registered AR value, no combinational path from any input.
REQ-013 SHALL have port busy  output  1  high while in state BURST.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a burst completes.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when an AR update wraps.

Function
REQ-016 SHALL implement a state machine with states IDLE, BURST, DONE.
REQ-017 In IDLE and DONE, command priority SHALL be CLR_clear > LD_load > INR_increment > DCR_decrement; at most one action per edge; no command holds AR.
REQ-018 All arithmetic SHALL be modulo 2^WIDTH.
REQ-019 wrap SHALL be high for the cycle after any edge where AR goes from all-ones to 0 by increment or from 0 to all-ones by decrement, including burst increments.
REQ-020 In IDLE, BST_start without CLR_clear SHALL load remaining counter with BST_count; next state is BURST if BST_count != 0, else DONE.
REQ-021 BST_start with LD_load in the same IDLE cycle SHALL load AR_input and begin the burst from that value; INR/DCR in that cycle are ignored.
REQ-022 In BURST, each edge SHALL increment AR and decrement remaining; the edge where remaining goes 1 -> 0 moves to DONE.
REQ-023 A burst of N >= 1 SHALL give busy high for exactly N cycles and exactly N increments.
REQ-024 In BURST, LD_load, INR_increment, DCR_decrement and BST_start SHALL be ignored.
REQ-025 CLR_clear in BURST SHALL set AR to 0 and go to IDLE without a done pulse.
REQ-026 DONE SHALL last exactly one cycle (done = 1) and then go to IDLE; BST_start in DONE is ignored.
REQ-027 BST_count = 0 SHALL produce a done pulse the cycle after BST_start, with AR unchanged except by a concurrent LD_load.

Reset
REQ-028 rst_reset SHALL override all inputs: AR_output = 0, state IDLE, remaining = 0, busy = 0, done = 0, wrap = 0 after the edge.
REQ-029 Reset asserted mid-burst SHALL abort it with no done pulse.

Structure
REQ-030 Shared package ar_pkg SHALL hold the state typedef (IDLE, BURST, DONE) and the default WIDTH / CNT_W constants.
REQ-031 The FSM and remaining counter SHALL be a sub-module ar_burst_ctrl; the datapath register stays in the top level.

Verification (WIDTH=12, CNT_W=4)
REQ-032 Reset: AR = 0x5A5, assert rst_reset with LD_load and AR_input = 0x777 -> AR_output = 0x000, busy/done/wrap = 0.
REQ-033 Priority: AR = 0x123, CLR+LD+INR -> 0x000; then LD+INR with AR_input = 0x0F0 -> 0x0F0; then INR+DCR -> 0x0F1.
REQ-034 Wrap: AR = 0xFFF, INR -> 0x000 with wrap high one cycle; then DCR -> 0xFFF with wrap high one cycle.
REQ-035 Burst: LD with AR_input = 0x100, BST_start and BST_count = 3 -> AR sequence 0x100, 0x101, 0x102, 0x103; busy high 3 cycles; then done high 1 cycle; INR during burst ignored.
REQ-036 Abort: burst with N = 8 from 0x010, CLR_clear after AR = 0x012 -> AR = 0x000, busy = 0 next cycle, done never asserted.
REQ-037 Zero length: BST_count = 0 at AR = 0x055 -> done pulse next cycle, busy never high, AR stays 0x055.
